dshot_command_controller: RTL

- Sequences decoded DShot frames from the frame-decode stage (throttle/command/CRC/telemetry fields) into motor-drive state.
- Enforces the arming sequence, special-command repeat qualification, spin-direction state and a signal-loss failsafe.
- Emits a registered throttle value to the downstream PWM/ESC output stage, plus command and telemetry strobes.

---
 rtl/dshot_command_controller_if.sv | 34 +++
 rtl/dshot_command_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dshot_command_controller_if.sv
// Decoded-frame inputs and drive-state outputs of the DShot command controller.
// The frame-decode side is the master; the controller is the slave.
interface dshot_command_controller_if;
   logic        frame_valid;
   logic [10:0] set_speed;
   logic [5:0]  special_command;
   logic        is_special_command;
   logic        crc_valid;
   logic        is_valid_speed;
   logic        telemetry_bit;

   logic [10:0] throttle_out;
   logic        armed;
   logic        failsafe;
   logic        motor_reverse;
   logic        command_strobe;
   logic [5:0]  command_out;
   logic        telemetry_req;
   logic [7:0]  crc_err_cnt;

   modport master (
      output frame_valid, set_speed, special_command, is_special_command,
             crc_valid, is_valid_speed, telemetry_bit,
      input  throttle_out, armed, failsafe, motor_reverse, command_strobe,
             command_out, telemetry_req, crc_err_cnt
   );

   modport slave (
      input  frame_valid, set_speed, special_command, is_special_command,
             crc_valid, is_valid_speed, telemetry_bit,
      output throttle_out, armed, failsafe, motor_reverse, command_strobe,
             command_out, telemetry_req, crc_err_cnt
   );
endinterface

// File: rtl/dshot_command_controller.sv
// Turns decoded DShot frames into motor-drive state: arming, command repeat
// qualification, spin direction, signal-loss failsafe and CRC error count.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_DISARMED | throttle forced to 0; counting consecutive zero frames to arm
// ST_ARMED    | throttle follows speed frames; commands executed; timeout live
// ST_FAILSAFE | signal lost; throttle held 0 until a zero frame is accepted
module dshot_command_controller #(
   parameter int ARM_FRAMES     = 10,
   parameter int REPEAT_CNT     = 6,
   parameter int TIMEOUT_CYCLES = 12500000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   dshot_command_controller_if.slave  bus
);

   localparam int AW = $clog2(ARM_FRAMES + 1);
   localparam int RW = $clog2(REPEAT_CNT + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_FAILSAFE = 2'd2
   } state_t;

   state_t      state_q,    state_d;
   logic [AW-1:0] arm_cnt_q, arm_cnt_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic [TW-1:0] to_cnt_q,  to_cnt_d;
   logic [5:0]  last_cmd_q, last_cmd_d;
   logic [10:0] throttle_q, throttle_d;
   logic        strobe_q,   strobe_d;
   logic [5:0]  cmd_out_q,  cmd_out_d;
   logic        tele_q,     tele_d;
   logic        reverse_q,  reverse_d;
   logic [7:0]  crc_err_q,  crc_err_d;

   logic          accept;
   logic          bad_crc;
   logic          zero_frame;
   logic          needs_rep;
   logic          same_cmd;
   logic          exec;
   logic [AW-1:0] arm_inc;
   logic [TW-1:0] to_inc;

   assign accept     = bus.frame_valid & bus.crc_valid;
   assign bad_crc    = bus.frame_valid & ~bus.crc_valid;
   assign zero_frame = (bus.set_speed == 11'd0);
   assign needs_rep  = (bus.special_command >= 6'd7) && (bus.special_command <= 6'd21);
   assign same_cmd   = (rep_cnt_q != '0) && (bus.special_command == last_cmd_q);
   assign arm_inc    = arm_cnt_q + 1'b1;
   assign to_inc     = to_cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_DISARMED;
         arm_cnt_q  <= '0;
         rep_cnt_q  <= '0;
         to_cnt_q   <= '0;
         last_cmd_q <= '0;
         throttle_q <= '0;
         strobe_q   <= 1'b0;
         cmd_out_q  <= '0;
         tele_q     <= 1'b0;
         reverse_q  <= 1'b0;
         crc_err_q  <= '0;
      end else begin
         state_q    <= state_d;
         arm_cnt_q  <= arm_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         to_cnt_q   <= to_cnt_d;
         last_cmd_q <= last_cmd_d;
         throttle_q <= throttle_d;
         strobe_q   <= strobe_d;
         cmd_out_q  <= cmd_out_d;
         tele_q     <= tele_d;
         reverse_q  <= reverse_d;
         crc_err_q  <= crc_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      arm_cnt_d  = arm_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      to_cnt_d   = to_cnt_q;
      last_cmd_d = last_cmd_q;
      throttle_d = throttle_q;
      strobe_d   = 1'b0;
      cmd_out_d  = cmd_out_q;
      tele_d     = 1'b0;
      reverse_d  = reverse_q;
      crc_err_d  = crc_err_q;
      exec       = 1'b0;

      if (bad_crc && (crc_err_q != 8'hFF)) begin
         crc_err_d = crc_err_q + 1'b1;
      end

      case (state_q)
         ST_DISARMED: begin
            throttle_d = '0;
            to_cnt_d   = '0;
            rep_cnt_d  = '0;
            if (accept) begin
               if (zero_frame) begin
                  if (arm_inc == AW'(ARM_FRAMES)) begin
                     state_d   = ST_ARMED;
                     arm_cnt_d = '0;
                  end else begin
                     arm_cnt_d = arm_inc;
                  end
               end else begin
                  arm_cnt_d = '0;
               end
            end
         end

         ST_ARMED: begin
            if (accept) begin
               // An accepted frame always beats a timeout landing on the same edge.
               to_cnt_d = '0;
               tele_d   = bus.telemetry_bit;
               if (bus.is_valid_speed) begin
                  throttle_d = bus.set_speed - 11'd48;
               end else begin
                  throttle_d = '0;
               end
               if (bus.is_special_command) begin
                  if (!same_cmd) begin
                     rep_cnt_d  = RW'(1);
                     last_cmd_d = bus.special_command;
                     exec       = !needs_rep || (REPEAT_CNT == 1);
                  end else if (rep_cnt_q != RW'(REPEAT_CNT)) begin
                     // Saturating at REPEAT_CNT keeps a long run from re-strobing.
                     rep_cnt_d = rep_cnt_q + 1'b1;
                     exec      = needs_rep && (rep_cnt_d == RW'(REPEAT_CNT));
                  end
               end else begin
                  rep_cnt_d = '0;
               end
            end else if (to_inc == TW'(TIMEOUT_CYCLES)) begin
               state_d    = ST_FAILSAFE;
               throttle_d = '0;
               to_cnt_d   = '0;
               rep_cnt_d  = '0;
            end else begin
               to_cnt_d = to_inc;
            end
         end

         ST_FAILSAFE: begin
            throttle_d = '0;
            to_cnt_d   = '0;
            rep_cnt_d  = '0;
            if (accept && zero_frame) begin
               state_d   = ST_DISARMED;
               arm_cnt_d = AW'(1);
            end
         end

         default: begin
            state_d    = ST_DISARMED;
            throttle_d = '0;
            arm_cnt_d  = '0;
            to_cnt_d   = '0;
            rep_cnt_d  = '0;
         end
      endcase

      if (exec) begin
         strobe_d  = 1'b1;
         cmd_out_d = bus.special_command;
         if (bus.special_command == 6'd20) reverse_d = 1'b0;
         if (bus.special_command == 6'd21) reverse_d = 1'b1;
      end
   end

   assign bus.throttle_out   = throttle_q;
   assign bus.armed          = (state_q == ST_ARMED);
   assign bus.failsafe       = (state_q == ST_FAILSAFE);
   assign bus.motor_reverse  = reverse_q;
   assign bus.command_strobe = strobe_q;
   assign bus.command_out    = cmd_out_q;
   assign bus.telemetry_req  = tele_q;
   assign bus.crc_err_cnt    = crc_err_q;

endmodule
